// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, register indices and the stack-pointer reset value.
// Imported by the register file, the control unit and the write-back mux.
package cpu_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [DATA_W-1:0] SP_RESET = 32'd128;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational register-file read port: r0 forced to zero, optional same-cycle write bypass.
// Zero latency; no flow control, the address is sampled continuously.
module reg_file_read_port
  import cpu_pkg::*;
#(
  parameter int P_DATA_W  = DATA_W,
  parameter int P_ADDR_W  = ADDR_W,
  parameter int P_REG_NUM = REG_NUM,
  parameter int BYPASS    = 1
) (
  input  logic [P_ADDR_W-1:0] addr,
  input  logic [P_DATA_W-1:0] regs [P_REG_NUM],
  input  logic                wr_en,
  input  logic [P_ADDR_W-1:0] wr_addr,
  input  logic [P_DATA_W-1:0] wr_dat,
  output logic [P_DATA_W-1:0] rd_dat
);
  logic addr_zero;
  logic byp_hit;

  assign addr_zero = (addr == '0);
  // wr_en arrives already qualified by reset and a non-zero destination.
  assign byp_hit   = (BYPASS != 0) && wr_en && (wr_addr == addr);

  always_comb begin
    rd_dat = regs[addr];
    if (addr_zero)
      rd_dat = '0;
    else if (byp_hit)
      rd_dat = wr_dat;
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous write port, r0 reads zero.
// Reads are zero latency (write forwarded when BYPASS=1); writes commit on the rising edge, no backpressure.
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int                 P_DATA_W  = DATA_W,
  parameter int                 P_REG_NUM = REG_NUM,
  parameter int                 P_ADDR_W  = ADDR_W,
  parameter int                 SP_IDX    = int'(REG_SP),
  parameter logic [P_DATA_W-1:0] P_SP_RESET = SP_RESET,
  parameter int                 BYPASS    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [P_ADDR_W-1:0] RSaddr_i,
  input  logic [P_ADDR_W-1:0] RTaddr_i,
  input  logic [P_ADDR_W-1:0] RDaddr_i,
  input  logic [P_DATA_W-1:0] RDdata_i,
  input  logic                RegWrite_i,
  output logic [P_DATA_W-1:0] RSdata_o,
  output logic [P_DATA_W-1:0] RTdata_o
);
  logic [P_DATA_W-1:0] regs [P_REG_NUM];
  logic                wr_en;

  // Held in reset, nothing commits and nothing is forwarded to the read ports.
  assign wr_en = rst_i && (RegWrite_i == 1'b1) && (RDaddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < P_REG_NUM; i++)
        regs[i] <= (i == SP_IDX) ? P_SP_RESET : '0;
    end else if (wr_en) begin
      regs[RDaddr_i] <= RDdata_i;
    end
  end

  reg_file_read_port #(
    .P_DATA_W (P_DATA_W),
    .P_ADDR_W (P_ADDR_W),
    .P_REG_NUM(P_REG_NUM),
    .BYPASS   (BYPASS)
  ) u_rs_port (
    .addr   (RSaddr_i),
    .regs   (regs),
    .wr_en  (wr_en),
    .wr_addr(RDaddr_i),
    .wr_dat (RDdata_i),
    .rd_dat (RSdata_o)
  );

  reg_file_read_port #(
    .P_DATA_W (P_DATA_W),
    .P_ADDR_W (P_ADDR_W),
    .P_REG_NUM(P_REG_NUM),
    .BYPASS   (BYPASS)
  ) u_rt_port (
    .addr   (RTaddr_i),
    .regs   (regs),
    .wr_en  (wr_en),
    .wr_addr(RDaddr_i),
    .wr_dat (RDdata_i),
    .rd_dat (RTdata_o)
  );

  // An unknown write enable outside reset means the control unit is broken.
  a_regwrite_known: assert property (@(posedge clk_i) disable iff (!rst_i) !$isunknown(RegWrite_i));
endmodule
